// File: rtl/core_inst_queue_pkg.sv
// Types and helpers shared by the instruction queue and decode.
// An entry holds {pc[31:2], inst}; the BPU side-band is appended by the queue.
package core_inst_queue_pkg;

    localparam int INST_W  = 32;
    localparam int N_SLOTS = 2;

    typedef struct packed {
        logic [29:0]       pc;
        logic [INST_W-1:0] inst;
    } inst_core_t;

    // Word-granular PC of a slot inside an aligned 8-byte fetch packet.
    function automatic logic [29:0] slot_pc(input logic [31:0] vpc, input logic slot);
        return {vpc[31:3], slot};
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/core_inst_queue_mpfifo.sv
// Generic circular FIFO accepting 0..2 writes and retiring 0..2 reads per cycle.
// Latency 1 cycle (no bypass); caller guarantees push/pop counts fit the free space / occupancy.
module core_mpfifo_2w2r #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic [1:0]             push_cnt_i,
    input  logic [1:0][WIDTH-1:0]  wdata_i,
    input  logic [1:0]             pop_cnt_i,
    output logic [1:0][WIDTH-1:0]  rdata_o,
    output logic [CW-1:0]          count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d, head_p1;
    logic [AW-1:0]    tail_q, tail_d, tail_p1;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        head_p1 = head_q + AW'(1);
        tail_p1 = tail_q + AW'(1);
        head_d  = head_q + AW'(pop_cnt_i);
        tail_d  = tail_q + AW'(push_cnt_i);
        count_d = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr_i) begin
            if (push_cnt_i != 2'd0) mem_q[tail_q]  <= wdata_i[0];
            if (push_cnt_i == 2'd2) mem_q[tail_p1] <= wdata_i[1];
        end
    end

    assign rdata_o[0] = mem_q[head_q];
    assign rdata_o[1] = mem_q[head_p1];
    assign count_o    = count_q;

endmodule

// File: rtl/core_inst_queue.sv
// Fetch-to-decode decoupling queue: compacts 2-slot fetch packets into per-instruction entries.
// Output valid the cycle after push; ready_o comes only from registered occupancy (needs 2 free slots).
module core_inst_queue
    import core_inst_queue_pkg::*;
#(
    parameter int DEPTH               = 8,
    parameter int ATTACHED_INFO_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr_i,
    input  logic [1:0]                          valid_i,
    input  logic [31:0]                         vpc_i,
    input  logic [1:0][31:0]                    inst_i,
    input  logic [ATTACHED_INFO_WIDTH-1:0]      attached_i,
    output logic                                ready_o,
    output logic [1:0]                          valid_o,
    output logic [1:0][31:0]                    pc_o,
    output logic [1:0][31:0]                    inst_o,
    output logic [1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
    input  logic                                ready_i
);

    localparam int EW = $bits(inst_core_t) + ATTACHED_INFO_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0][EW-1:0]  wdata, rdata;
    logic [1:0]          push_cnt, pop_cnt;
    logic [CW-1:0]       count;
    inst_core_t [1:0]    wr_core, rd_core;
    logic                push_fire;
    logic                unused_vpc_lo;

    assign unused_vpc_lo = ^vpc_i[2:0];

    assign ready_o   = (count <= CW'(DEPTH - 2));
    assign valid_o   = {count >= CW'(2), count != '0};
    assign push_fire = ready_o && (|valid_i) && !clr_i;
    assign push_cnt  = push_fire ? popcount2(valid_i) : 2'd0;
    assign pop_cnt   = (ready_i && !clr_i) ? popcount2(valid_o) : 2'd0;

    always_comb begin
        wr_core[0] = '{pc: slot_pc(vpc_i, 1'b0), inst: inst_i[0]};
        wr_core[1] = '{pc: slot_pc(vpc_i, 1'b1), inst: inst_i[1]};
        wdata[0]   = {wr_core[0], attached_i};
        wdata[1]   = {wr_core[1], attached_i};
        // A lone slot1 instruction is compacted into the first write port.
        if (valid_i == 2'b10) wdata[0] = {wr_core[1], attached_i};
    end

    core_mpfifo_2w2r #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .push_cnt_i (push_cnt),
        .wdata_i    (wdata),
        .pop_cnt_i  (pop_cnt),
        .rdata_o    (rdata),
        .count_o    (count)
    );

    for (genvar k = 0; k < 2; k++) begin : g_out
        assign {rd_core[k], attached_o[k]} = rdata[k];
        assign pc_o[k]   = {rd_core[k].pc, 2'b00};
        assign inst_o[k] = rd_core[k].inst;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
            assert (push_cnt == 2'd0 || ready_o);
            assert (valid_o != 2'b10);
        end
    end
`endif

endmodule

// File: doc/core_inst_queue.md
Name: core_inst_queue

Overview:
- Decoupling buffer between instruction fetch and decode.
- Accepts an aligned 8-byte fetch packet per cycle: up to 2 instructions, with a per-slot valid mask.
- Compacts the packet into a per-instruction circular FIFO.
- Presents up to 2 oldest instructions per cycle to decode. Drives the fetch stage's ready_i and is flushed by the same clear as fetch.

Parameters:
- DEPTH, 8, entries (instructions); power of 2, >= 4.
- ATTACHED_INFO_WIDTH, 32, width of BPU side-band carried per packet; copied into each instruction's entry.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clr_i  in  1  flush (redirect); synchronous
- valid_i  in  2  per-slot valid of incoming packet (slot0 = pc+0, slot1 = pc+4)
- vpc_i  in  32  packet virtual PC; bits [2:0] ignored
- inst_i  in  2x32  instruction words, slot-indexed
- attached_i  in  ATTACHED_INFO_WIDTH  packet side-band
- ready_o  out  1  to fetch; packet accepted when ready_o && |valid_i
- valid_o  out  2  output valid, compacted (valid_o[1] implies valid_o[0])
- pc_o  out  2x32  PC of each output instruction
- inst_o  out  2x32  output instruction words
- attached_o  out  2xATTACHED_INFO_WIDTH  side-band of each output instruction
- ready_i  in  1  from decode; consumes all asserted valid_o this cycle

Behaviour:
- Storage: DEPTH entries {pc[31:2], inst[31:0], attached}. Head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH. Count register 0..DEPTH, log2(DEPTH)+1 bits.
- Reset (rst=1): head=tail=count=0; valid_o=2'b00; ready_o=1 from the following cycle. Data contents are don't-care.
- Flush (clr_i=1): same pointer/count effect as reset. Any push or pop in that cycle is discarded. Flush has priority over all other events.
- ready_o = (DEPTH - count_q) >= 2, derived only from registered count, with no combinational path from ready_i or valid_i.
- Push, when ready_o && |valid_i && !clr_i:
  - 2'b11: writes slot0 at tail, slot1 at tail+1; pcs {vpc[31:3],3'b000} and {vpc[31:3],3'b100}.
  - 2'b01: writes slot0 only, pc {vpc[31:3],3'b000}.
  - 2'b10: writes slot1 only, at tail; pc {vpc[31:3],3'b100}.
  - tail advances by popcount(valid_i).
- Output, combinational from registered state:
  - valid_o[0] = count>=1; valid_o[1] = count>=2.
  - Entry head drives slot 0; entry head+1 (wrapped) drives slot 1.
  - Outputs for invalid slots are don't-care. pc_o[1:0] = 2'b00.
- Pop: when ready_i && !clr_i, head advances by popcount(valid_o).
- Latency: a pushed instruction appears on valid_o no earlier than the cycle after the push (no bypass).
- Simultaneous push and pop: count_next = count + pushed - popped. Exact at boundaries; ready_o the next cycle reflects the new count.
- Full boundary: with count = DEPTH-1, ready_o=0 even if a pop is occurring. Conservative, by design.
- Empty boundary: with count=0, valid_o=00 and ready_i is ignored.
- Wrap-around: a 2-instruction push or pop straddling index DEPTH-1 -> 0 must be correct.
- Order: program order is strictly preserved. Slot0 of a packet precedes slot1.
- Assertions (sim only):
  - count never exceeds DEPTH.
  - no push when !ready_o.
  - valid_o never 2'b10.

Decomposition:
- Shared header (pipeline.svh): typedef inst_q_entry_t {pc[31:2], inst, attached} and the PC-slot construction helper, both shared with decode.
- Natural single sub-module: core_mpfifo_2w2r, a generic 2-write/2-read circular FIFO with variable push/pop counts 0..2. core_inst_queue then holds only packet compaction, PC generation and the ready/flush glue.

Test Plan:
1. Reset then push vpc=0x1C000008, valid=11, inst={0xA,0xB} -> next cycle valid_o=11, pc_o={0x1C00000C,0x1C000008}, inst_o={0xB,0xA}. Pop -> count=0, valid_o=00.
2. Push valid=10 at vpc=0x1C000010 (slot1 inst 0xC) -> valid_o=01, pc_o[0]=0x1C000014, inst_o[0]=0xC.
3. Fill with ready_i=0 via 11 packets -> after 4 pushes count=8 and ready_o=0. With count=6 ready_o=1; with count=7 ready_o=0. Then one pop of 2 -> ready_o=1 next cycle.
4. Steady state, push 11 and pop 2 every cycle across 20 cycles -> count constant. PCs emerge in order across the index 7->0 wrap, with no duplicates or drops.
5. clr_i asserted with count=5 while a push and a pop are both presented -> next cycle count=0, valid_o=00, ready_o=1. The discarded push never appears.
6. rst asserted mid-stream with count=3 -> next cycle valid_o=00, ready_o=1. A subsequent push at vpc=0x0 yields pc_o[0]=0x0.
